// File: rtl/ram_uart_pkg.sv
// rtl/ram_uart_pkg.sv - shared types and helpers for the RAM-to-UART dumper
package ram_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        FINISH
    } state_t;

    localparam int UART_DATA_BITS = 8;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/ram_uart_dumper_if.sv
// rtl/ram_uart_dumper_if.sv - read port of the shared result RAM
interface ram_uart_dumper_if #(
    parameter int addr_width = 32,
    parameter int data_width = 32
);
    logic                  ram_we;
    logic [addr_width-1:0] ram_addr;
    logic [data_width-1:0] ram_rdata;

    modport master (output ram_we, output ram_addr, input ram_rdata);
    modport slave  (input ram_we, input ram_addr, output ram_rdata);
endinterface

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer with valid/ready handshake
module uart_tx_byte
    import ram_uart_pkg::*;
#(
    parameter int clks_per_bit = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);
    localparam int cw = $clog2(clks_per_bit);
    localparam logic [cw-1:0] cnt_last = cw'(clks_per_bit - 1);
    localparam logic [2:0]    bit_last = 3'(UART_DATA_BITS - 1);

    state_t       state;
    logic [cw-1:0] cnt;
    logic [2:0]   bit_idx;
    logic [7:0]   shreg;
    logic         bit_end;

    assign bit_end = (cnt == cnt_last);
    // Ready during the final stop-bit cycle lets the next byte follow with no gap.
    assign ready   = (state == IDLE) || (state == STOP_BIT && bit_end);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (valid) begin
                        shreg <= data;
                        tx    <= 1'b0;
                        state <= START_BIT;
                    end
                end
                START_BIT: if (bit_end) begin
                    tx      <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_idx <= '0;
                    state   <= DATA_BITS;
                end
                DATA_BITS: if (bit_end) begin
                    if (bit_idx == bit_last) begin
                        tx    <= 1'b1;
                        state <= STOP_BIT;
                    end else begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                STOP_BIT: if (bit_end) begin
                    if (valid) begin
                        shreg <= data;
                        tx    <= 1'b0;
                        state <= START_BIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/ram_uart_dumper.sv
// rtl/ram_uart_dumper.sv - fetches words from the result RAM and sends them LSB-byte first over UART
module ram_uart_dumper
    import ram_uart_pkg::*;
#(
    parameter int addr_width   = 32,
    parameter int data_width   = 32,
    parameter int clks_per_bit = 868
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [addr_width-1:0] base_addr,
    input  logic [addr_width-1:0] word_count,
    ram_uart_dumper_if.master     ram,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);
    localparam int bpw = bytes_per_word(data_width);
    localparam int bw  = (bpw > 1) ? $clog2(bpw) : 1;
    localparam logic [bw-1:0] idx_last = bw'(bpw - 1);

    state_t                state;
    logic [addr_width-1:0] remaining;
    logic [data_width-1:0] shifter;
    logic [bw-1:0]         byte_idx;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [7:0]            tx_data;

    assign ram.ram_we = 1'b0;

    // Byte 0 goes straight from the RAM output so the first start bit lands right after LOAD.
    assign tx_data  = (state == LOAD) ? ram.ram_rdata[7:0] : shifter[7:0];
    assign tx_valid = (state == LOAD) ||
                      (state == START_BIT && tx_ready && byte_idx != idx_last);

    uart_tx_byte #(.clks_per_bit(clks_per_bit)) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (tx_valid),
        .data  (tx_data),
        .ready (tx_ready),
        .tx    (tx)
    );

    // START_BIT here means "bytes of the current word are on the line"; bit timing lives in u_tx.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            ram.ram_addr <= '0;
            remaining    <= '0;
            shifter      <= '0;
            byte_idx     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    ram.ram_addr <= base_addr;
                    remaining    <= word_count;
                    if (word_count == '0) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        state <= FETCH;
                        busy  <= 1'b1;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    shifter   <= ram.ram_rdata >> 8;
                    byte_idx  <= '0;
                    remaining <= remaining - 1'b1;
                    state     <= START_BIT;
                end
                START_BIT: if (tx_ready) begin
                    if (byte_idx != idx_last) begin
                        byte_idx <= byte_idx + 1'b1;
                        shifter  <= shifter >> 8;
                    end else if (remaining != '0) begin
                        ram.ram_addr <= ram.ram_addr + 1'b1;
                        state        <= FETCH;
                    end else begin
                        state <= FINISH;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_uart_dumper.sv
// tb/tb_ram_uart_dumper.sv - scoreboard bench for ram_uart_dumper at 4 clocks per bit
module tb_ram_uart_dumper;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] base_addr;
    logic [3:0] word_count;
    logic       tx;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0;

    logic [31:0] mem [16];
    logic [7:0]  exp_q[$];
    int          done_q[$];
    int          start_q[$];

    ram_uart_dumper_if #(.addr_width(4), .data_width(32)) ram_bus ();

    ram_uart_dumper #(.addr_width(4), .data_width(32), .clks_per_bit(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .ram        (ram_bus),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) ram_bus.ram_rdata <= mem[ram_bus.ram_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) step();
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(w >> (8 * i)));
    endtask

    // Start sampled in cycle t0; returns at T1 after checking busy and captured address.
    task automatic do_start(input logic [3:0] b, input logic [3:0] n, input bit expect_done);
        step();
        t0 = cyc;
        start = 1'b1;
        base_addr = b;
        word_count = n;
        if (expect_done) done_q.push_back(t0 + 162 * int'(n) + 1);
        step();
        start = 1'b0;
        chk("busy_t1", {31'b0, busy}, {31'b0, (n != 0)});
        chk("ram_addr_t1", {28'b0, ram_bus.ram_addr}, {28'b0, b});
    endtask

    // UART receiver: samples each bit mid-way and scores the byte against the queue.
    initial begin : uart_mon
        logic [7:0] b;
        logic       stop_v;
        bit         abort;
        int         st;
        forever begin
            step();
            if (rst_n === 1'b1 && tx === 1'b0) begin
                st = cyc;
                abort = 1'b0;
                b = '0;
                stop_v = 1'b0;
                for (int k = 1; k <= 38; k++) begin
                    step();
                    if (rst_n !== 1'b1) begin
                        abort = 1'b1;
                        break;
                    end
                    if (k >= 6 && k <= 34 && (k % 4) == 2) b[(k - 6) / 4] = tx;
                    if (k == 38) stop_v = tx;
                end
                if (!abort) begin
                    start_q.push_back(st);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL uart_unexpected_byte at cycle %0d: got %h expected none", cyc, b);
                    end else begin
                        chk("uart_byte", {24'b0, b}, {24'b0, exp_q.pop_front()});
                    end
                    chk("uart_stop_bit", {31'b0, stop_v}, 32'd1);
                end
            end
        end
    end

    initial begin : done_mon
        forever begin
            step();
            if (done === 1'b1) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected at cycle %0d: got 1 expected 0", cyc);
                end else begin
                    chk("done_cycle", cyc, done_q.pop_front());
                    chk("busy_at_done", {31'b0, busy}, 32'd0);
                end
            end
        end
    end

    initial begin : stim
        int ts;
        int lim;
        rst_n = 1'b0;
        start = 1'b1;
        base_addr = 4'd5;
        word_count = 4'd1;
        for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 | i;
        mem[5]  = 32'h1234_5678;
        mem[15] = 32'hA5A5_A5A5;
        mem[0]  = 32'h0000_00FF;
        mem[1]  = 32'hDEAD_BEEF;

        repeat (3) step();
        chk("reset_tx", {31'b0, tx}, 32'd1);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_ram_addr", {28'b0, ram_bus.ram_addr}, 32'd0);
        chk("reset_ram_we", {31'b0, ram_bus.ram_we}, 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        step();
        chk("start_at_reset_release_busy", {31'b0, busy}, 32'd0);
        step();
        chk("start_at_reset_release_tx", {31'b0, tx}, 32'd1);

        // Single word, then a back-to-back start in the first IDLE cycle after done.
        push_word(32'h1234_5678);
        do_start(4'd5, 4'd1, 1'b1);
        step();
        step();
        chk("first_start_bit_t3", {31'b0, tx}, 32'd0);
        wait_cyc(t0 + 163);
        push_word(32'h1234_5678);
        do_start(4'd5, 4'd1, 1'b1);
        wait_cyc(t0 + 164);

        // Two words with address wrap 15 -> 0.
        start_q.delete();
        push_word(32'hA5A5_A5A5);
        push_word(32'h0000_00FF);
        do_start(4'd15, 4'd2, 1'b1);
        ts = t0;
        wait_cyc(ts + 163);
        chk("wrap_ram_addr", {28'b0, ram_bus.ram_addr}, 32'd0);
        chk("gap_tx_fetch", {31'b0, tx}, 32'd1);
        step();
        chk("gap_tx_load", {31'b0, tx}, 32'd1);
        step();
        chk("word2_start_bit", {31'b0, tx}, 32'd0);
        wait_cyc(ts + 327);
        chk("wrap_byte_count", start_q.size(), 32'd8);
        if (start_q.size() == 8) begin
            chk("first_start_cycle", start_q[0], ts + 3);
            chk("intra_word_spacing", start_q[1] - start_q[0], 32'd40);
            chk("inter_word_spacing", start_q[4] - start_q[3], 32'd42);
        end

        // Zero count: done at T1, busy and tx never move.
        do_start(4'd3, 4'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("zero_busy", {31'b0, busy}, 32'd0);
            chk("zero_tx", {31'b0, tx}, 32'd1);
            step();
        end

        // A second start mid-transfer must be ignored.
        push_word(32'h1234_5678);
        do_start(4'd5, 4'd1, 1'b1);
        ts = t0;
        wait_cyc(ts + 50);
        start = 1'b1;
        base_addr = 4'd0;
        word_count = 4'd3;
        step();
        start = 1'b0;
        wait_cyc(ts + 210);
        chk("ignored_start_busy", {31'b0, busy}, 32'd0);
        chk("ignored_start_tx", {31'b0, tx}, 32'd1);

        // Reset during a data bit of byte 2, then a fresh transfer.
        exp_q.push_back(8'h78);
        exp_q.push_back(8'h56);
        do_start(4'd5, 4'd1, 1'b0);
        ts = t0;
        wait_cyc(ts + 97);
        rst_n = 1'b0;
        step();
        chk("midbit_reset_tx", {31'b0, tx}, 32'd1);
        chk("midbit_reset_busy", {31'b0, busy}, 32'd0);
        chk("midbit_reset_done", {31'b0, done}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        push_word(32'h1234_5678);
        do_start(4'd5, 4'd1, 1'b1);

        lim = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && lim < 2000) begin
            step();
            lim++;
        end
        if (lim >= 2000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d bytes %0d dones pending expected 0", exp_q.size(), done_q.size());
        end
        repeat (50) step();
        chk("final_exp_q_empty", exp_q.size(), 32'd0);
        chk("final_done_q_empty", done_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
